// File: rtl/bpm_pkg.sv
// rtl/bpm_pkg.sv - shared FSM states and ASCII constants for the BPM UART reporter
package bpm_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONV       = 3'd1,
        SEND_START = 3'd2,
        SEND_DATA  = 3'd3,
        SEND_STOP  = 3'd4,
        NEXT_BYTE  = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Frame is hundreds, tens, ones, CR, LF: byte index 4 is the last one.
    localparam logic [2:0] LAST_BYTE  = 3'd4;

    function automatic logic [7:0] to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'd0, digit};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 bit timing for one byte; done pulses in the last cycle of each of the start, data and stop phases
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_byte,
    input  logic       load,
    output logic       tx,
    output logic       done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_START = 2'd1,
        PH_DATA  = 2'd2,
        PH_STOP  = 2'd3
    } phase_t;

    phase_t        phase;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          bit_end;

    assign bit_end = (phase != PH_IDLE) && (timer == T_LAST);
    assign done    = bit_end && ((phase != PH_DATA) || (bit_idx == 3'd7));
    assign tx      = tx_q;

    // tx is registered so the line level changes exactly on the bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= PH_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else if (load) begin
            phase   <= PH_START;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= data_byte;
            tx_q    <= 1'b0;
        end else if (phase != PH_IDLE) begin
            if (!bit_end) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
                case (phase)
                    PH_START: begin
                        phase <= PH_DATA;
                        tx_q  <= shreg[0];
                    end
                    PH_DATA: begin
                        if (bit_idx == 3'd7) begin
                            phase <= PH_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end
                    default: begin
                        phase <= PH_IDLE;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/bpm_uart_reporter.sv
// rtl/bpm_uart_reporter.sv - captures a BPM result, converts it to decimal ASCII and sends "ddd\r\n" over UART
module bpm_uart_reporter
    import bpm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] bpm_value,
    input  logic       bpm_valid,
    output logic       bpm_copied,
    output logic       uart_tx,
    output logic       busy
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rem;
    logic [1:0] hund;
    logic [3:0] tens;
    logic [2:0] byte_idx;
    logic [7:0] cur_byte;
    logic       capture;
    logic       conv_last;
    logic       load;
    logic       phase_done;
    logic       tx_line;

    assign conv_last = (rem < 8'd10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (capture)    state_nxt = CONV;
            CONV:       if (conv_last)  state_nxt = SEND_START;
            SEND_START: if (phase_done) state_nxt = SEND_DATA;
            SEND_DATA:  if (phase_done) state_nxt = SEND_STOP;
            SEND_STOP:  if (phase_done) state_nxt = (byte_idx == LAST_BYTE) ? IDLE : NEXT_BYTE;
            NEXT_BYTE:  state_nxt = SEND_START;
            default:    state_nxt = IDLE;
        endcase
    end

    // Gating with rst_n keeps bpm_copied and busy low while reset is held.
    always_comb begin
        capture    = 1'b0;
        bpm_copied = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        capture    = rst_n && (state == IDLE) && en && bpm_valid;
        bpm_copied = capture;
        busy       = (state != IDLE) || capture;
        load       = ((state == CONV) && conv_last) || (state == NEXT_BYTE);
    end

    // rem doubles as the captured value and the running remainder of the conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            hund     <= '0;
            tens     <= '0;
            byte_idx <= '0;
        end else if (capture) begin
            rem      <= bpm_value;
            hund     <= '0;
            tens     <= '0;
            byte_idx <= '0;
        end else if (state == CONV) begin
            if (rem >= 8'd100) begin
                rem  <= rem - 8'd100;
                hund <= hund + 2'd1;
            end else if (rem >= 8'd10) begin
                rem  <= rem - 8'd10;
                tens <= tens + 4'd1;
            end
        end else if ((state == SEND_STOP) && phase_done && (byte_idx != LAST_BYTE)) begin
            byte_idx <= byte_idx + 3'd1;
        end
    end

    always_comb begin
        cur_byte = ASCII_LF;
        case (byte_idx)
            3'd0:    cur_byte = to_ascii({2'b00, hund});
            3'd1:    cur_byte = to_ascii(tens);
            3'd2:    cur_byte = to_ascii(rem[3:0]);
            3'd3:    cur_byte = ASCII_CR;
            default: cur_byte = ASCII_LF;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_byte (cur_byte),
        .load      (load),
        .tx        (tx_line),
        .done      (phase_done)
    );

    assign uart_tx = tx_line;

endmodule
